// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and flow-control unit for the 5-stage core. It drives stall/flush of
// the PC, IF/ID and ID/EX registers for load-use bubbles, branch/trap
// redirects and multi-cycle (mul/div) EX freezes, guarded by a watchdog.
//
// Handshake note: there is no valid/ready channel here. mc_done_i is a
// 1-cycle pulse from the multi-cycle unit; mc_kill_o is a 1-cycle abort
// request that the unit must honour in the same cycle it is seen.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   id_rs1_i/id_rs2_i       source regs of the ID instruction (+ *_used_i)
//   ex_rd_i, ex_mem_read_i  destination / load flag of the EX instruction
//   ex_mc_start_i           EX instruction is mul/div, issued this cycle
//   mc_done_i               multi-cycle result valid pulse
//   ex_redirect_i, trap_i   taken branch/jump, exception/interrupt
//   pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o
//   mc_kill_o, mc_timeout_o multi-cycle abort / registered watchdog pulse
//   *_cnt_o                 performance counters (0 unless enabled)
//   state_dbg_o             current FSM state (0 = RUN, 1 = MC_WAIT)
//
// Optional feature macro: HAZARD_PERF_CNT_EN builds the three counters.
module pipeline_hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_mc_start_i,
  input  logic             mc_done_i,
  input  logic             ex_redirect_i,
  input  logic             trap_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             mc_kill_o,
  output logic             mc_timeout_o,
  output logic [CNT_W-1:0] lu_stall_cnt_o,
  output logic [CNT_W-1:0] mc_stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             state_dbg_o
);

  localparam int WD_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            mc_timeout_q, mc_timeout_d;
  logic            lu_hit;

  // rd==0 is x0 and can never carry a hazard.
  assign lu_hit = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                  ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                   (id_rs2_used_i && (id_rs2_i == ex_rd_i)));

  always_comb begin
    state_d       = state_q;
    wd_cnt_d      = wd_cnt_q;
    mc_timeout_d  = 1'b0;
    pc_stall_o    = 1'b0;
    if_id_stall_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    mc_kill_o     = 1'b0;
    if (trap_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      mc_kill_o     = (state_q == ST_MC_WAIT);
      state_d       = ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (ex_redirect_i) begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (ex_mc_start_i) begin
        pc_stall_o    = 1'b1;
        if_id_stall_o = 1'b1;
        id_ex_flush_o = 1'b1;
        state_d       = ST_MC_WAIT;
        wd_cnt_d      = '0;
      end else if (lu_hit) begin
        pc_stall_o    = 1'b1;
        if_id_stall_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end
    end else begin
      // MC_WAIT: done releases the freeze in the same cycle so the held ID
      // instruction advances on the next edge.
      if (mc_done_i) begin
        state_d = ST_RUN;
      end else begin
        pc_stall_o    = 1'b1;
        if_id_stall_o = 1'b1;
        id_ex_flush_o = 1'b1;
        if (wd_cnt_q == WD_W'(MC_TIMEOUT - 1)) begin
          mc_kill_o    = 1'b1;
          mc_timeout_d = 1'b1;
          state_d      = ST_RUN;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      wd_cnt_q     <= '0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_cnt_q     <= wd_cnt_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  assign id_ex_stall_o = 1'b0;
  assign mc_timeout_o  = mc_timeout_q;
  assign state_dbg_o   = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;
  logic             lu_evt, mc_evt, fl_evt;

  assign lu_evt = (state_q == ST_RUN) && !trap_i && !ex_redirect_i &&
                  !ex_mc_start_i && lu_hit;
  // Any other PC stall comes from the multi-cycle freeze.
  assign mc_evt = pc_stall_o && !lu_evt;
  assign fl_evt = if_id_flush_o;

  always_comb begin
    lu_cnt_d = lu_cnt_q + (lu_evt ? CNT_W'(1) : CNT_W'(0));
    mc_cnt_d = mc_cnt_q + (mc_evt ? CNT_W'(1) : CNT_W'(0));
    fl_cnt_d = fl_cnt_q + (fl_evt ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lu_cnt_q <= '0;
      mc_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      mc_cnt_q <= mc_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign lu_stall_cnt_o = lu_cnt_q;
  assign mc_stall_cnt_o = mc_cnt_q;
  assign flush_cnt_o    = fl_cnt_q;
`else
  assign lu_stall_cnt_o = '0;
  assign mc_stall_cnt_o = '0;
  assign flush_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. Two instances share all inputs:
// u0 with MC_TIMEOUT=64 and u1 with MC_TIMEOUT=8 (watchdog scenarios).
module tb_pipeline_hazard_ctrl;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic rs1_used, rs2_used, mem_read, mc_start, mc_done, redirect, trap;

  logic          pc_stall [2];
  logic          if_stall [2];
  logic          if_flush [2];
  logic          ex_stall [2];
  logic          ex_flush [2];
  logic          kill     [2];
  logic          tmo_o    [2];
  logic          st       [2];
  logic [CW-1:0] lu_c     [2];
  logic [CW-1:0] mc_c     [2];
  logic [CW-1:0] fl_c     [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MC_TIMEOUT(64), .CNT_W(CW)) u0 (
    .clk(clk), .rst_n(rst_n), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used), .ex_rd_i(ex_rd),
    .ex_mem_read_i(mem_read), .ex_mc_start_i(mc_start), .mc_done_i(mc_done),
    .ex_redirect_i(redirect), .trap_i(trap), .pc_stall_o(pc_stall[0]),
    .if_id_stall_o(if_stall[0]), .if_id_flush_o(if_flush[0]),
    .id_ex_stall_o(ex_stall[0]), .id_ex_flush_o(ex_flush[0]),
    .mc_kill_o(kill[0]), .mc_timeout_o(tmo_o[0]), .lu_stall_cnt_o(lu_c[0]),
    .mc_stall_cnt_o(mc_c[0]), .flush_cnt_o(fl_c[0]), .state_dbg_o(st[0]));

  pipeline_hazard_ctrl #(.MC_TIMEOUT(8), .CNT_W(CW)) u1 (
    .clk(clk), .rst_n(rst_n), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used), .ex_rd_i(ex_rd),
    .ex_mem_read_i(mem_read), .ex_mc_start_i(mc_start), .mc_done_i(mc_done),
    .ex_redirect_i(redirect), .trap_i(trap), .pc_stall_o(pc_stall[1]),
    .if_id_stall_o(if_stall[1]), .if_id_flush_o(if_flush[1]),
    .id_ex_stall_o(ex_stall[1]), .id_ex_flush_o(ex_flush[1]),
    .mc_kill_o(kill[1]), .mc_timeout_o(tmo_o[1]), .lu_stall_cnt_o(lu_c[1]),
    .mc_stall_cnt_o(mc_c[1]), .flush_cnt_o(fl_c[1]), .state_dbg_o(st[1]));

  // ---------------- behavioural model ----------------
  // Per instance: busy = waiting on mul/div, elapsed = 1-based MC_WAIT cycle
  // number, to = watchdog pulse owed this cycle, plus event totals.
  int            tmo_lim [2] = '{64, 8};
  bit            m_busy [2], n_busy [2];
  int            m_elap [2], n_elap [2];
  bit            m_to   [2], n_to   [2];
  logic [CW-1:0] m_lu [2], m_mc [2], m_fl [2];
  logic [CW-1:0] n_lu [2], n_mc [2], n_fl [2];
  logic [7:0]    exp_q [$];
  logic [3*CW-1:0] cexp_q [$];

  // Vector order: pc_stall, if_stall, if_flush, ex_stall, ex_flush, kill, timeout, state
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit hz, ps, fi, fe, kl, mcs;
      logic [7:0] act, e;
      logic [3*CW-1:0] cact, ce;
      hz = mem_read && ex_rd != 0 &&
           ((rs1_used && id_rs1 == ex_rd) || (rs2_used && id_rs2 == ex_rd));
      ps = 0; fi = 0; fe = 0; kl = 0; mcs = 0;
      n_busy[i] = m_busy[i]; n_elap[i] = m_elap[i]; n_to[i] = 0;
      if (trap) begin
        fi = 1; fe = 1; kl = m_busy[i]; n_busy[i] = 0;
      end else if (m_busy[i]) begin
        if (mc_done) n_busy[i] = 0;
        else begin
          ps = 1; fe = 1; mcs = 1;
          if (m_elap[i] == tmo_lim[i]) begin
            kl = 1; n_busy[i] = 0; n_to[i] = 1;
          end else n_elap[i] = m_elap[i] + 1;
        end
      end else if (redirect) begin
        fi = 1; fe = 1;
      end else if (mc_start) begin
        ps = 1; fe = 1; mcs = 1; n_busy[i] = 1; n_elap[i] = 1;
      end else if (hz) begin
        ps = 1; fe = 1;
      end
      n_lu[i] = m_lu[i] + ((ps && !mcs) ? 1 : 0);
      n_mc[i] = m_mc[i] + (mcs ? 1 : 0);
      n_fl[i] = m_fl[i] + (fi ? 1 : 0);
      exp_q.push_back({ps, ps, fi, 1'b0, fe, kl, m_to[i], m_busy[i]});
`ifdef HAZARD_PERF_CNT_EN
      cexp_q.push_back({m_lu[i], m_mc[i], m_fl[i]});
`else
      cexp_q.push_back('0);
`endif
      act  = {pc_stall[i], if_stall[i], if_flush[i], ex_stall[i], ex_flush[i],
              kill[i], tmo_o[i], st[i]};
      cact = {lu_c[i], mc_c[i], fl_c[i]};
      e  = exp_q.pop_front();
      ce = cexp_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL outputs u%0d t=%0t: got %b want %b", i, $time, act, e);
      end
      n_cmp++;
      if (cact !== ce) begin
        n_err++;
        $display("FAIL counters u%0d t=%0t: got %h want %h", i, $time, cact, ce);
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 0; m_elap[i] = 0; m_to[i] = 0;
        m_lu[i] = '0; m_mc[i] = '0; m_fl[i] = '0;
      end else begin
        m_busy[i] = n_busy[i]; m_elap[i] = n_elap[i]; m_to[i] = n_to[i];
        m_lu[i] = n_lu[i]; m_mc[i] = n_mc[i]; m_fl[i] = n_fl[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; rs1_used = 0; rs2_used = 0;
    ex_rd = 5'd0; mem_read = 0; mc_start = 0; mc_done = 0;
    redirect = 0; trap = 0;
  endtask

  // Literal check, sampled 2 time units after the inputs settle.
  task automatic chk(input string name, input logic [CW-1:0] act,
                     input logic [CW-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  function automatic logic [CW-1:0] pc(input logic [CW-1:0] v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return '0 & v;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int stalls;
    logic [CW-1:0] c0;
    idle();
    rst_n = 0;
    step(2);
    rst_n = 1;
    #2;
    chk("reset_pc_stall", pc_stall[0], 0);
    chk("reset_state", st[0], 0);
    chk("reset_flush_cnt", fl_c[0], 0);

    // 1. load x5 in EX, ID reads rs2=5
    step(1);
    ex_rd = 5'd5; mem_read = 1; id_rs1 = 5'd3; id_rs2 = 5'd5;
    rs1_used = 1; rs2_used = 1;
    #2;
    chk("lu_pc_stall", pc_stall[0], 1);
    chk("lu_if_stall", if_stall[0], 1);
    chk("lu_ex_flush", ex_flush[0], 1);
    step(1);
    mem_read = 0; ex_rd = 5'd7;  // load moved to MEM
    #2;
    chk("lu_next_cycle", pc_stall[0], 0);
    chk("lu_cnt", lu_c[0], pc(1));
    step(1);
    ex_rd = 5'd0; mem_read = 1; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #2;
    chk("lu_x0_no_stall", pc_stall[0], 0);
    step(1);
    ex_rd = 5'd9; id_rs1 = 5'd9; rs1_used = 0; id_rs2 = 5'd1;
    #2;
    chk("lu_unused_rs1", pc_stall[0], 0);

    // 2. redirect with a load-use match
    step(1);
    rs1_used = 1; redirect = 1;
    #2;
    chk("redir_if_flush", if_flush[0], 1);
    chk("redir_ex_flush", ex_flush[0], 1);
    chk("redir_pc_stall", pc_stall[0], 0);
    step(1);
    idle();
    #2;
    chk("redir_flush_cnt", fl_c[0], pc(1));

    // 3. mul/div done after 10 wait cycles (u0)
    c0 = mc_c[0];
    stalls = 0;
    step(1);
    mc_start = 1;
    #2;
    stalls += int'(pc_stall[0]);
    for (int k = 0; k < 10; k++) begin
      step(1);
      mc_start = 0;
      #2;
      stalls += int'(pc_stall[0]);
    end
    step(1);
    mc_done = 1;
    #2;
    chk("mc_done_cycle_stall", pc_stall[0], 0);
    chk("mc_stall_cycles", stalls, 11);
    step(1);
    mc_done = 0;
    #2;
    chk("mc_state_run", st[0], 0);
    chk("mc_stall_cnt", mc_c[0] - c0, pc(11));

    // 4. watchdog on u1 (MC_TIMEOUT=8)
    step(1);
    mc_start = 1;
    step(1);
    mc_start = 0;
    step(7);
    #2;
    chk("wd_kill_8th", kill[1], 1);
    chk("wd_no_pulse_yet", tmo_o[1], 0);
    step(1);
    #2;
    chk("wd_pulse", tmo_o[1], 1);
    chk("wd_state_run", st[1], 0);
    step(1);
    #2;
    chk("wd_pulse_once", tmo_o[1], 0);
    mc_done = 1;  // release u0, still waiting
    step(1);
    mc_done = 0;

    // 5. trap in the 3rd MC_WAIT cycle
    mc_start = 1;
    step(1);
    mc_start = 0;
    step(2);
    trap = 1;
    #2;
    chk("trap_kill", kill[0], 1);
    chk("trap_if_flush", if_flush[0], 1);
    chk("trap_pc_stall", pc_stall[0], 0);
    step(1);
    trap = 0;
    #2;
    chk("trap_state_run", st[0], 0);

    // 6. reset in the middle of MC_WAIT
    mc_start = 1;
    step(1);
    mc_start = 0;
    step(3);
    rst_n = 0;
    step(1);
    rst_n = 1;
    #2;
    chk("rst_state", st[0], 0);
    chk("rst_pc_stall", pc_stall[0], 0);
    chk("rst_mc_cnt", mc_c[0], 0);
    chk("rst_lu_cnt", lu_c[1], 0);

    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and flow-control unit for the 5-stage core. It drives the stall and flush inputs of the PC, IF/ID and ID/EX pipeline registers: load-use bubbles, branch/trap redirect flushes, and multi-cycle (mul/div) EX freezes with a watchdog.
The ID/EX register loads a bubble (all-zero) whenever its stall or flush input is high. This unit relies on that: the ID/EX bubble is always requested via id_ex_flush_o, and id_ex_stall_o is reserved and driven 0.

Parameters:
MC_TIMEOUT, 64, max cycles in MC_WAIT before watchdog abort (>=2)
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
id_rs1_i  in  5  rs1 of instruction in ID
id_rs2_i  in  5  rs2 of instruction in ID
id_rs1_used_i  in  1  ID instruction reads rs1
id_rs2_used_i  in  1  ID instruction reads rs2
ex_rd_i  in  5  rd of instruction in EX
ex_mem_read_i  in  1  EX instruction is a load
ex_mc_start_i  in  1  EX instruction is mul/div, issued this cycle
mc_done_i  in  1  multi-cycle unit result valid (1-cycle pulse)
ex_redirect_i  in  1  taken branch/jump resolved in EX
trap_i  in  1  exception/interrupt redirect
pc_stall_o  out  1  hold PC
if_id_stall_o  out  1  hold IF/ID
if_id_flush_o  out  1  clear IF/ID
id_ex_stall_o  out  1  reserved, always 0
id_ex_flush_o  out  1  load bubble into ID/EX
mc_kill_o  out  1  abort multi-cycle unit
mc_timeout_o  out  1  registered 1-cycle watchdog pulse
lu_stall_cnt_o  out  CNT_W  load-use stall cycles
mc_stall_cnt_o  out  CNT_W  multi-cycle stall cycles
flush_cnt_o  out  CNT_W  redirect/trap flush events

Behaviour:
- Reset (rst_n=0 at clk edge): state=RUN, watchdog count=0, mc_timeout_o=0, counters=0.
- Control outputs are combinational from state and inputs. They are all 0 in RUN when inputs are idle.
- FSM states: RUN, MC_WAIT.
- Priority within a cycle: trap_i > ex_redirect_i > multi-cycle > load-use.
- Trap (any state):
  - if_id_flush_o=1, id_ex_flush_o=1, stalls=0.
  - If state=MC_WAIT, also mc_kill_o=1 and next state=RUN.
- Redirect (RUN only): if_id_flush_o=1, id_ex_flush_o=1, pc_stall_o=0. The PC loads the target. Penalty is 2 bubbles.
- Multi-cycle start (RUN, ex_mc_start_i=1, no trap/redirect):
  - pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1.
  - Next state=MC_WAIT, watchdog count cleared.
- MC_WAIT without mc_done_i:
  - Same three outputs asserted; count increments.
  - Load-use and redirect inputs are ignored.
- MC_WAIT with mc_done_i: outputs deasserted that cycle, so the ID instruction advances on the next edge. Next state=RUN.
- Watchdog: in MC_WAIT, if count==MC_TIMEOUT-1 and no mc_done_i:
  - mc_kill_o=1 that cycle; next state=RUN.
  - mc_timeout_o=1 on the following cycle only.
  - mc_done_i and timeout in the same cycle: done wins, no timeout.
- Load-use (RUN, none of the above):
  - Detected when ex_mem_read_i=1, ex_rd_i!=0, and (rs1_used && rs1==rd or rs2_used && rs2==rd).
  - Outputs: pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1 for exactly that cycle.
  - The next cycle, the load sits in MEM and no longer matches.
- ex_rd_i==0 never causes a stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - lu_stall_cnt_o increments each load-use stall cycle.
  - mc_stall_cnt_o increments each cycle pc_stall_o=1 due to multi-cycle (start cycle and MC_WAIT).
  - flush_cnt_o increments each trap or redirect cycle.
  - All counters wrap at 2^CNT_W and reset to 0.
- Undefined: the three counter ports are tied to 0 and no counter flops are built.

Test Plan:
1. Load x5 in EX (ex_rd_i=5, ex_mem_read_i=1), ID add uses rs2=5 -> exactly 1 cycle pc_stall_o=if_id_stall_o=id_ex_flush_o=1; ex_rd_i=0 case -> no stall.
2. ex_redirect_i=1 together with a load-use match -> if_id_flush_o=id_ex_flush_o=1, pc_stall_o=0; flush_cnt_o +1 (with macro).
3. ex_mc_start_i=1, mc_done_i after 10 cycles -> stalls high 11 cycles, low in done cycle, state RUN; mc_stall_cnt_o=11.
4. MC_TIMEOUT=8, no mc_done_i -> mc_kill_o high in the 8th MC_WAIT cycle, mc_timeout_o pulse next cycle, then RUN.
5. trap_i in the 3rd MC_WAIT cycle -> mc_kill_o=1, both flushes=1, stalls=0, next state RUN.
6. rst_n=0 mid MC_WAIT -> state RUN, all outputs 0, counters 0 after the reset edge.
